pc_unit: RTL

Parametrised program-counter unit for the reduced RISC-V core, the successor to the single-mode PC register. It holds the fetch PC and selects the next PC from one of four sources: sequential, PC-relative branch, register-indirect jump, or return-address-stack pop. It adds stall, trap redirection, misalignment detection and a circular return-address stack (RAS). It sits between the control unit and instruction memory and feeds `pc_out` to fetch and `pc_plus4` to the writeback link path.

---
 rtl/pc_unit_if.sv | 28 ++
 rtl/pc_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/fetch-side bundle of the program-counter unit.
// The master (control unit) drives the next-PC controls.
// The slave (pc_unit) returns the PC, the link value and the RAS status.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             trap;
  logic [1:0]       jmp_sel;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] rs1_val;
  logic             ras_push;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus4;
  logic             misaligned;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, trap, jmp_sel, ImmOp, rs1_val, ras_push,
    input  pc_out, pc_plus4, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, trap, jmp_sel, ImmOp, rs1_val, ras_push,
    output pc_out, pc_plus4, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with four next-PC sources (sequential,
// PC-relative, register-indirect, return-address-stack pop), stall, trap
// redirection, target misalignment trapping and a circular RAS.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);

  // Pointer width; count needs one extra bit to represent "full".
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [WIDTH-1:0] C_FOUR      = WIDTH'(32'd4);
  localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] C_ZERO_W    = WIDTH'(32'd0);
  localparam logic [PW-1:0]    C_PTR_ONE   = PW'(32'd1);
  localparam logic [PW-1:0]    C_PTR_ZERO  = PW'(32'd0);
  localparam logic [CW-1:0]    C_CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0]    C_CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0]    C_CNT_DEPTH = CW'(RAS_DEPTH);

  // Architectural state
  logic [WIDTH-1:0] r_pc;
  logic             r_mis;
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  // Datapath
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_jump_sum;
  logic [WIDTH-1:0] w_target;
  logic             w_empty;
  logic             w_full;
  logic             w_misalign;

  // Next-state
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_mis_nxt;
  logic [PW-1:0]    w_top_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_wr_en;
  logic [PW-1:0]    w_wr_idx;
  logic             w_do_push;
  logic             w_do_pop;

  // Candidate target selection and alignment check for the current controls.
  always_comb begin
    w_pc_plus4 = r_pc + C_FOUR;
    w_jump_sum = bus.rs1_val + bus.ImmOp;
    w_empty    = (r_cnt == C_CNT_ZERO);
    w_full     = (r_cnt == C_CNT_DEPTH);
    case (bus.jmp_sel)
      2'b00:   w_target = w_pc_plus4;
      2'b01:   w_target = r_pc + bus.ImmOp;
      2'b10:   w_target = w_jump_sum & ~C_ONE;
      2'b11:   w_target = w_empty ? w_pc_plus4 : r_ras[r_top];
      default: w_target = w_pc_plus4;
    endcase
    // Sequential targets are aligned by construction and are not checked.
    if (bus.jmp_sel != 2'b00) begin
      w_misalign = (w_target[1:0] != 2'b00);
    end else begin
      w_misalign = 1'b0;
    end
  end

  // Next PC, pulse and RAS pointer/count under trap > stall > normal priority.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_mis_nxt = r_mis;
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_top;
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    if (bus.trap) begin
      w_pc_nxt  = TRAP_VECTOR;
      w_mis_nxt = 1'b0;
    end else if (bus.stall) begin
      w_pc_nxt  = r_pc;
      w_mis_nxt = r_mis;
    end else if (w_misalign) begin
      // Faulting redirect: no stack traffic at all.
      w_pc_nxt  = TRAP_VECTOR;
      w_mis_nxt = 1'b1;
    end else begin
      w_pc_nxt  = w_target;
      w_mis_nxt = 1'b0;
      w_do_push = bus.ras_push;
      w_do_pop  = (bus.jmp_sel == 2'b11) && !w_empty;
      if (w_do_push && w_do_pop) begin
        // Return and call together: replace the top in place.
        w_wr_en  = 1'b1;
        w_wr_idx = r_top;
      end else if (w_do_push) begin
        // When full the next slot is the oldest entry, so it is overwritten.
        w_wr_en   = 1'b1;
        w_wr_idx  = r_top + C_PTR_ONE;
        w_top_nxt = r_top + C_PTR_ONE;
        w_cnt_nxt = w_full ? r_cnt : (r_cnt + C_CNT_ONE);
      end else if (w_do_pop) begin
        w_top_nxt = r_top - C_PTR_ONE;
        w_cnt_nxt = r_cnt - C_CNT_ONE;
      end else begin
        w_wr_en = 1'b0;
      end
    end
  end

  // PC, misaligned pulse and RAS bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_VECTOR;
      r_mis <= 1'b0;
      r_top <= C_PTR_ZERO;
      r_cnt <= C_CNT_ZERO;
    end else begin
      r_pc  <= w_pc_nxt;
      r_mis <= w_mis_nxt;
      r_top <= w_top_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // RAS storage; cleared on reset so no X can ever leak into the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= C_ZERO_W;
      end
    end else if (w_wr_en) begin
      r_ras[w_wr_idx] <= w_pc_plus4;
    end else begin
      r_ras[w_wr_idx] <= r_ras[w_wr_idx];
    end
  end

  assign bus.pc_out     = r_pc;
  assign bus.pc_plus4   = w_pc_plus4;
  assign bus.misaligned = r_mis;
  assign bus.ras_empty  = w_empty;
  assign bus.ras_full   = w_full;

endmodule
